// File: rtl/bcd_up_counter_2d.sv
// Two-digit BCD up-counter from 00 to LIMIT_MSB:LIMIT_LSB; saturates (stop) or wraps (carry pulse).
// Latency: one clock from en/clr to the registered digits, stop and carry.
// Backpressure: none; en is a level qualifier, clr has priority and HALTED ignores en.
module bcd_up_counter_2d #(
    parameter int BCD_BIT_WIDTH = 4,
    parameter int LIMIT_MSB     = 5,
    parameter int LIMIT_LSB     = 9,
    parameter int WRAP          = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    output logic [BCD_BIT_WIDTH-1:0] lsb,
    output logic [BCD_BIT_WIDTH-1:0] msb,
    output logic                     stop,
    output logic                     carry
);

    typedef enum logic {COUNTING = 1'b0, HALTED = 1'b1} state_t;

    localparam logic [BCD_BIT_WIDTH-1:0] DIG_MAX = BCD_BIT_WIDTH'(9);
    localparam logic [BCD_BIT_WIDTH-1:0] LIM_L   = BCD_BIT_WIDTH'(LIMIT_LSB);
    localparam logic [BCD_BIT_WIDTH-1:0] LIM_M   = BCD_BIT_WIDTH'(LIMIT_MSB);
    localparam bit                       WRAP_EN = (WRAP != 0);

    state_t                   state_q, state_d;
    logic [BCD_BIT_WIDTH-1:0] lsb_q, lsb_d, msb_q, msb_d;
    logic                     carry_q, carry_d;
    logic [BCD_BIT_WIDTH-1:0] lsb_inc, msb_inc;
    logic                     at_limit, next_at_limit;

    // Any digit at or above 9 (including corrupted 10..15) rolls to 0 on a step.
    always_comb begin
        lsb_inc = (lsb_q >= DIG_MAX) ? '0 : lsb_q + 1'b1;
        msb_inc = msb_q;
        if (lsb_q >= DIG_MAX) begin
            msb_inc = (msb_q >= DIG_MAX) ? '0 : msb_q + 1'b1;
        end
        at_limit      = (lsb_q == LIM_L) && (msb_q == LIM_M);
        next_at_limit = (lsb_inc == LIM_L) && (msb_inc == LIM_M);
    end

    always_comb begin
        state_d = state_q;
        lsb_d   = lsb_q;
        msb_d   = msb_q;
        carry_d = 1'b0;
        if (clr) begin
            state_d = COUNTING;
            lsb_d   = '0;
            msb_d   = '0;
        end else begin
            case (state_q)
                COUNTING: begin
                    // Only reachable for a 00 limit (after reset or clr): halt without a step.
                    if (!WRAP_EN && at_limit) begin
                        state_d = HALTED;
                    end else if (en) begin
                        if (WRAP_EN && at_limit) begin
                            lsb_d   = '0;
                            msb_d   = '0;
                            carry_d = 1'b1;
                        end else begin
                            lsb_d = lsb_inc;
                            msb_d = msb_inc;
                            if (!WRAP_EN && next_at_limit) begin
                                state_d = HALTED;
                            end
                        end
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = COUNTING;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COUNTING;
            lsb_q   <= '0;
            msb_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lsb_q   <= lsb_d;
            msb_q   <= msb_d;
            carry_q <= carry_d;
        end
    end

    assign lsb   = lsb_q;
    assign msb   = msb_q;
    assign stop  = (state_q == HALTED);
    assign carry = carry_q;

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// Randomized bench for bcd_up_counter_2d: three instances (59 saturate, 59 wrap, 00 saturate)
// share stimulus and are each checked every cycle against an integer-valued reference model.
module tb_bcd_up_counter_2d;

    localparam int NINST = 3;
    localparam int L_MSB [NINST] = '{5, 5, 0};
    localparam int L_LSB [NINST] = '{9, 9, 0};
    localparam int L_WRAP[NINST] = '{0, 1, 0};

    // Elaboration-time guard against illegal digit limits.
    if (L_MSB[0] > 9 || L_LSB[0] > 9 || L_MSB[1] > 9 || L_LSB[1] > 9 ||
        L_MSB[2] > 9 || L_LSB[2] > 9 || L_MSB[0] < 0 || L_LSB[0] < 0 ||
        L_MSB[1] < 0 || L_LSB[1] < 0 || L_MSB[2] < 0 || L_LSB[2] < 0) begin : g_bad_limit
        initial $fatal(1, "illegal BCD limit parameter (digits must be 0..9)");
    end

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] lsb_o   [NINST];
    logic [3:0] msb_o   [NINST];
    logic       stop_o  [NINST];
    logic       carry_o [NINST];

    int n_chk = 0;
    int n_err = 0;

    int mval  [NINST];
    bit mhalt [NINST];
    bit mcarry[NINST];

    always #5 clk = ~clk;

    bcd_up_counter_2d #(.BCD_BIT_WIDTH(4), .LIMIT_MSB(L_MSB[0]), .LIMIT_LSB(L_LSB[0]), .WRAP(L_WRAP[0])) u_sat59 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .lsb(lsb_o[0]), .msb(msb_o[0]), .stop(stop_o[0]), .carry(carry_o[0]));

    bcd_up_counter_2d #(.BCD_BIT_WIDTH(4), .LIMIT_MSB(L_MSB[1]), .LIMIT_LSB(L_LSB[1]), .WRAP(L_WRAP[1])) u_wrap59 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .lsb(lsb_o[1]), .msb(msb_o[1]), .stop(stop_o[1]), .carry(carry_o[1]));

    bcd_up_counter_2d #(.BCD_BIT_WIDTH(4), .LIMIT_MSB(L_MSB[2]), .LIMIT_LSB(L_LSB[2]), .WRAP(L_WRAP[2])) u_sat00 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .lsb(lsb_o[2]), .msb(msb_o[2]), .stop(stop_o[2]), .carry(carry_o[2]));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NINST; i++) begin
            mval[i]   = 0;
            mhalt[i]  = 1'b0;
            mcarry[i] = 1'b0;
        end
    endfunction

    // Counter as a plain integer 0..99 with a halted flag.
    function automatic void model_tick(input bit e, input bit c);
        int lim;
        for (int i = 0; i < NINST; i++) begin
            lim       = L_MSB[i] * 10 + L_LSB[i];
            mcarry[i] = 1'b0;
            if (c) begin
                mval[i]  = 0;
                mhalt[i] = 1'b0;
            end else if (mhalt[i]) begin
                mhalt[i] = 1'b1;
            end else if (L_WRAP[i] == 0 && mval[i] == lim) begin
                mhalt[i] = 1'b1;
            end else if (e) begin
                if (mval[i] == lim) begin
                    mval[i]   = 0;
                    mcarry[i] = 1'b1;
                end else begin
                    mval[i] = (mval[i] + 1) % 100;
                    if (L_WRAP[i] == 0 && mval[i] == lim) mhalt[i] = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_all(input string ph);
        for (int i = 0; i < NINST; i++) begin
            chk($sformatf("%s.lsb%0d", ph, i),   int'(lsb_o[i]),   mval[i] % 10);
            chk($sformatf("%s.msb%0d", ph, i),   int'(msb_o[i]),   mval[i] / 10);
            chk($sformatf("%s.stop%0d", ph, i),  int'(stop_o[i]),  int'(mhalt[i]));
            chk($sformatf("%s.carry%0d", ph, i), int'(carry_o[i]), int'(mcarry[i]));
        end
    endtask

    task automatic step(input bit e, input bit c, input string ph);
        @(negedge clk);
        en  = e;
        clr = c;
        @(posedge clk);
        model_tick(e, c);
        #1;
        check_all(ph);
    endtask

    // Assert reset between edges and confirm outputs clear before the next clock edge.
    task automatic async_reset(input string ph);
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(ph);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Count 00..10, then on to saturation / wrap at 59.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, "up10");
        chk("up10.val", int'(msb_o[0]) * 10 + int'(lsb_o[0]), 10);
        chk("sat00.first_edge_stop", int'(stop_o[2]), 1);
        for (int k = 10; k < 59; k++) step(1'b1, 1'b0, "up59");
        chk("sat59.val", int'(msb_o[0]) * 10 + int'(lsb_o[0]), 59);
        chk("sat59.stop", int'(stop_o[0]), 1);
        step(1'b1, 1'b0, "wrap");
        chk("wrap.val", int'(msb_o[1]) * 10 + int'(lsb_o[1]), 0);
        chk("wrap.carry", int'(carry_o[1]), 1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, "hold59");
        chk("hold59.val", int'(msb_o[0]) * 10 + int'(lsb_o[0]), 59);

        // clr while HALTED, then resume.
        step(1'b0, 1'b1, "clr_halt");
        chk("clr_halt.stop", int'(stop_o[0]), 0);
        step(1'b1, 1'b0, "resume");

        // clr and en together at 37.
        async_reset("rst_a");
        for (int k = 0; k < 37; k++) step(1'b1, 1'b0, "to37");
        step(1'b1, 1'b1, "clr_en");
        chk("clr_en.val", int'(msb_o[0]) * 10 + int'(lsb_o[0]), 0);

        // en toggling from 08.
        async_reset("rst_b");
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, "to08");
        step(1'b1, 1'b0, "tog");
        step(1'b0, 1'b0, "tog");
        step(1'b1, 1'b0, "tog");
        step(1'b0, 1'b0, "tog");
        chk("tog.val", int'(msb_o[0]) * 10 + int'(lsb_o[0]), 10);

        // Async reset at 42.
        for (int k = 0; k < 32; k++) step(1'b1, 1'b0, "to42");
        chk("at42.val", int'(msb_o[0]) * 10 + int'(lsb_o[0]), 42);
        async_reset("rst42");
        step(1'b0, 1'b0, "post_rst");
        chk("post_rst.sat00_stop", int'(stop_o[2]), 1);

        // Random phase.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_up_counter_2d.md
Name: bcd_up_counter_2d

Overview:
Two-digit BCD up-counter for the stopwatch count-up mode. It counts from 00 toward a parameterised limit, advancing one step per qualified enable cycle. At the limit it either saturates and halts, or wraps to 00 and emits a one-cycle carry pulse. It drives the same lsb/msb digit outputs and stop flag that the display path already consumes from the countdown block.

Parameters:
BCD_BIT_WIDTH, 4, width of each BCD digit (fixed at 4).
LIMIT_MSB, 5, tens digit of the terminal count (legal range 0..9).
LIMIT_LSB, 9, units digit of the terminal count (legal range 0..9).
WRAP, 0, 0 = saturate and halt at limit; 1 = wrap to 00 and pulse carry.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable, level; each high cycle is one count step
clr  input  1  synchronous clear to 00, restarts counting
lsb  output  4  units BCD digit, registered
msb  output  4  tens BCD digit, registered
stop  output  1  high while halted at limit (WRAP=0 only)
carry  output  1  one-cycle pulse at wrap to 00 (WRAP=1 only)

Behaviour:
- Reset (rst_n=0, asynchronous): lsb=0, msb=0, carry=0, state=COUNTING, stop=0. Exception: if the limit is 00 and WRAP=0, stop goes high on the first edge after reset deassertion.
- States: COUNTING and HALTED. stop = (state==HALTED). All outputs are registered; no combinational path from inputs to outputs.
- COUNTING, en=1, value below limit:
  - lsb<9: lsb+1.
  - lsb==9: lsb=0, msb+1. The internal units-to-tens carry applies in the same cycle, so value update latency is 1 clock.
- COUNTING, en=1, value == limit:
  - WRAP=0: value holds; state goes to HALTED on this edge; stop rises in the same cycle the limit value appears.
    - Transition rule: on the edge where the next value equals the limit, state moves to HALTED. stop therefore coincides with the display showing the limit.
  - WRAP=1: value becomes 00 on this edge; carry=1 for exactly one cycle, coincident with the 00 display.
- COUNTING, en=0: value holds; carry=0.
- HALTED: en is ignored; value holds at the limit; carry stays 0. Only clr or rst_n leave this state.
- clr=1: on the next edge, value=00, state=COUNTING, carry=0.
  - clr has priority over en in the same cycle; no count step occurs in that cycle.
  - After clr, if the limit is 00 and WRAP=0, the next edge re-halts.
- carry is 0 in every cycle not immediately following a wrap edge. carry is never asserted when WRAP=0.
- Digits never take values 10..15.
  - Parameter values outside 0..9 are illegal; the bench must flag them with an elaboration-time check.
  - Any digit value above 9 from corruption is treated as 9 plus one (i.e. rolls to 0) and is never held.
- Reset asserted mid-count or while HALTED: immediate return to reset values, independent of clk.

Test Plan:
- Reset, then en=1 for 10 cycles (defaults) -> sequence 00,01,…,09,10; msb increments on the same edge lsb goes 9→0; stop=0, carry=0 throughout.
- Defaults, en=1 for 59 cycles -> reaches 59 and stop=1 in that cycle; 5 more en cycles -> value stays 59, stop stays 1.
- WRAP=1, en=1 for 60 cycles -> 59 then 00; carry=1 only in the 00 cycle, 0 before and after; stop always 0.
- Counting at 37, assert clr and en together -> next value 00, not 38; with clr while HALTED at 59 -> 00, stop=0, counting resumes on the next en.
- en toggled 1,0,1,0 from 08 -> 09, 09, 10, 10; hold cycles produce no carry pulse.
- Assert rst_n low asynchronously mid-cycle at value 42 -> lsb=0, msb=0 before the next clk edge; LIMIT_MSB=0, LIMIT_LSB=0, WRAP=0 -> stop=1 on the first edge after release.
